// File: rtl/datapath_ctrl.sv
// Command sequencer for the accumulator datapath: accepts op requests over
// valid/ready and expands each one into single-cycle cmd/d_out issues.
module datapath_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [REP_W-1:0] req_rep,
    input  logic [WIDTH-1:0] req_data,
    output logic [2:0]       cmd,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [2:0] CMD_HOLD = 3'b000;
    localparam logic [2:0] CMD_CAP  = 3'b001;
    localparam logic [2:0] CMD_ADD  = 3'b010;
    localparam logic [2:0] CMD_SUB  = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [REP_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [2:0]         cmd_d;
    logic [WIDTH-1:0]   d_out_d;
    logic               busy_d;
    logic               done_d;

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign req_ready = rst_n && (state_q == IDLE);

    // State, latched request and registered outputs.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
            cmd     <= CMD_HOLD;
            d_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cmd     <= cmd_d;
            d_out   <= d_out_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state, plus output values for the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        cmd_d   = CMD_HOLD;
        d_out_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    data_d  = req_data;
                    cnt_d   = (req_op == OP_ADD || req_op == OP_SUB) ? req_rep : '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - REP_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        if (state_d == ISSUE) begin
            case (op_d)
                OP_LOAD:  begin cmd_d = CMD_CAP; d_out_d = data_d; end
                OP_ADD:   begin cmd_d = CMD_ADD; d_out_d = data_d; end
                OP_SUB:   begin cmd_d = CMD_SUB; d_out_d = data_d; end
                OP_CLEAR: begin cmd_d = CMD_CAP; d_out_d = '0;     end
                default:  begin cmd_d = CMD_HOLD; d_out_d = '0;    end
            endcase
        end
    end

endmodule
